// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller:
// forwarding select codes, data-memory wait FSM states, register index width.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one E-stage source operand. M wins over W and
// register x0 is never forwarded because it is hard-wired to zero.
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] rs_e,
  input  logic          v_m,
  input  logic          regwrite_m,
  input  logic [AW-1:0] rd_m,
  input  logic          v_w,
  input  logic          regwrite_w,
  input  logic [AW-1:0] rd_w,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_REG;
    if (v_m && regwrite_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (v_w && regwrite_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the F/D/E/M/W pipeline: stage valids, stalls,
// redirect kill and E-stage forwarding. Optional counters: PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_valid,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              memread_E,
  input  logic              redirect_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic              regwrite_M,
  input  logic              dmem_req_M,
  input  logic              dmem_ready,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              regwrite_W,
  output logic              pc_en,
  output logic              en_FD,
  output logic              en_DE,
  output logic              en_EM,
  output logic              en_MW,
  output logic              v_D,
  output logic              v_E,
  output logic              v_M,
  output logic              v_W,
  output logic [FWD_W-1:0]  fwd_a_E,
  output logic [FWD_W-1:0]  fwd_b_E,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]       cnt_lu,
  output logic [31:0]       cnt_mem,
  output logic [31:0]       cnt_red,
`endif
  output logic              mem_busy
);

  import pipe_ctrl_pkg::*;

  mem_state_t state_q, state_d;
  logic v_d_q, v_d_d, v_e_q, v_e_d, v_m_q, v_m_d, v_w_q, v_w_d;
  logic mstall, red, lu;
  logic win_mem, win_red, win_lu;

  assign mstall = v_m_q & dmem_req_M & ~dmem_ready;
  assign red    = v_e_q & redirect_E;
  assign lu     = v_e_q & v_d_q & memread_E & (rd_E != '0) &
                  ((use_rs1_D & (rd_E == rs1_D)) | (use_rs2_D & (rd_E == rs2_D)));

  // A stalled memory access freezes everything, so it must outrank a redirect.
  assign win_mem = mstall;
  assign win_red = ~mstall & red;
  assign win_lu  = ~mstall & ~red & lu;

  always_comb begin
    pc_en   = imem_valid;
    en_FD   = 1'b1;
    en_DE   = 1'b1;
    en_EM   = 1'b1;
    en_MW   = 1'b1;
    v_d_d   = imem_valid;
    v_e_d   = v_d_q;
    v_m_d   = v_e_q;
    v_w_d   = v_m_q;
    state_d = state_q;

    if (win_mem) begin
      pc_en = 1'b0;
      en_FD = 1'b0;
      en_DE = 1'b0;
      en_EM = 1'b0;
      en_MW = 1'b0;
      v_d_d = v_d_q;
      v_e_d = v_e_q;
      v_m_d = v_m_q;
      v_w_d = 1'b0;
    end else if (win_red) begin
      // Wrong-path F and D instructions die; the branch itself moves on to M.
      pc_en = 1'b1;
      v_d_d = 1'b0;
      v_e_d = 1'b0;
      v_m_d = 1'b1;
    end else if (win_lu) begin
      pc_en = 1'b0;
      en_FD = 1'b0;
      en_DE = 1'b0;
      v_d_d = v_d_q;
      v_e_d = 1'b0;
    end

    case (state_q)
      MEM_IDLE: if (mstall)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mstall) state_d = MEM_IDLE;
      default:               state_d = MEM_IDLE;
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cnt_lu_q, cnt_lu_d, cnt_mem_q, cnt_mem_d, cnt_red_q, cnt_red_d;

  always_comb begin
    cnt_lu_d  = cnt_lu_q;
    cnt_mem_d = cnt_mem_q;
    cnt_red_d = cnt_red_q;
    if (win_lu  && (cnt_lu_q  != 32'hFFFF_FFFF)) cnt_lu_d  = cnt_lu_q  + 32'd1;
    if (win_mem && (cnt_mem_q != 32'hFFFF_FFFF)) cnt_mem_d = cnt_mem_q + 32'd1;
    if (win_red && (cnt_red_q != 32'hFFFF_FFFF)) cnt_red_d = cnt_red_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_q  <= '0;
      cnt_mem_q <= '0;
      cnt_red_q <= '0;
    end else begin
      cnt_lu_q  <= cnt_lu_d;
      cnt_mem_q <= cnt_mem_d;
      cnt_red_q <= cnt_red_d;
    end
  end

  assign cnt_lu  = cnt_lu_q;
  assign cnt_mem = cnt_mem_q;
  assign cnt_red = cnt_red_q;
`endif

  // NOTE: reset is sampled on the clock edge here, so rst is just another
  // synchronous input and mid-stall reset takes effect on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      v_d_q   <= 1'b0;
      v_e_q   <= 1'b0;
      v_m_q   <= 1'b0;
      v_w_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every stage read the pre-edge value of
      // its neighbour, which is what makes the valid bits shift correctly.
      state_q <= state_d;
      v_d_q   <= v_d_d;
      v_e_q   <= v_e_d;
      v_m_q   <= v_m_d;
      v_w_q   <= v_w_d;
    end
  end

  assign v_D      = v_d_q;
  assign v_E      = v_e_q;
  assign v_M      = v_m_q;
  assign v_W      = v_w_q;
  assign mem_busy = (state_q == MEM_WAIT);

  pipe_fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .rs_e       (rs1_E),
    .v_m        (v_m_q),
    .regwrite_m (regwrite_M),
    .rd_m       (rd_M),
    .v_w        (v_w_q),
    .regwrite_w (regwrite_W),
    .rd_w       (rd_W),
    .sel        (fwd_a_E)
  );

  pipe_fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .rs_e       (rs2_E),
    .v_m        (v_m_q),
    .regwrite_m (regwrite_M),
    .rd_m       (rd_M),
    .v_w        (v_w_q),
    .regwrite_w (regwrite_W),
    .rd_w       (rd_W),
    .sel        (fwd_b_E)
  );

endmodule
